// File: rtl/io_pkg.sv
// Shared types and constants for the user input front-end.
package io_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int BTN_ENTER  = 0;
  localparam int BTN_CLEAR  = 1;
  localparam int BTN_COMMIT = 2;
  localparam int BTN_CANCEL = 3;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/button_debounce.sv
// One push button: two-flop synchronizer, stability counter and a
// registered rising-edge detect that yields a single-cycle press strobe.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 200
) (
  input  logic CLK,
  input  logic nRST,
  input  logic btn,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             level_p2;
  logic             level_p3;
  logic             pulse_p3;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt_p2   <= '0;
      level_p2 <= 1'b0;
      level_p3 <= 1'b0;
      pulse_p3 <= 1'b0;
    end else begin
      // p0/p1: metastability synchronizer
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // p2: accept a level change only after it has stayed stable
      if (sync_p1 != level_p2) begin
        if (cnt_p2 == CNT_LAST) begin
          level_p2 <= sync_p1;
          cnt_p2   <= '0;
        end else begin
          cnt_p2 <= cnt_p2 + 1'b1;
        end
      end else begin
        cnt_p2 <= '0;
      end
      // p3: rising edge of the debounced level
      level_p3 <= level_p2;
      pulse_p3 <= level_p2 & ~level_p3;
    end
  end

  assign press_pulse = pulse_p3;

endmodule

// File: rtl/user_input_capture.sv
// Debounced button front-end that assembles switch nibbles into a 16-bit
// word and hands it to the control FSM over a Valid/Ack handshake.
module user_input_capture
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int N_DIGITS        = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  Slide_Switch,
  input  logic [3:0]  Button,
  input  logic        Ack,
  output logic [15:0] Data_Out,
  output logic [2:0]  Digit_Count,
  output logic        Valid,
  output logic [3:0]  Press_Pulse,
  output logic        Full
);

  logic [DIGIT_W-1:0] sw_p0;
  logic [DIGIT_W-1:0] sw_p1;
  state_t             state;
  state_t             state_n;
  logic [15:0]        data_n;
  logic [2:0]         count_n;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK        (CLK),
      .nRST       (nRST),
      .btn        (Button[b]),
      .press_pulse(Press_Pulse[b])
    );
  end

  assign Full  = (Digit_Count == 3'(N_DIGITS));
  assign Valid = (state == HOLD);

  // Cancel beats commit beats clear beats enter; only the winner acts.
  always_comb begin
    state_n = state;
    data_n  = Data_Out;
    count_n = Digit_Count;
    case (state)
      EMPTY: begin
        if (Press_Pulse[BTN_ENTER] && !Press_Pulse[BTN_CLEAR] &&
            !Press_Pulse[BTN_COMMIT] && !Press_Pulse[BTN_CANCEL]) begin
          data_n  = {12'd0, sw_p1};
          count_n = 3'd1;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (Press_Pulse[BTN_CANCEL]) begin
          data_n  = '0;
          count_n = '0;
          state_n = EMPTY;
        end else if (Press_Pulse[BTN_COMMIT]) begin
          state_n = HOLD;
        end else if (Press_Pulse[BTN_CLEAR]) begin
          data_n  = {4'd0, Data_Out[15:4]};
          count_n = Digit_Count - 3'd1;
          if (Digit_Count == 3'd1) state_n = EMPTY;
        end else if (Press_Pulse[BTN_ENTER] && !Full) begin
          data_n  = {Data_Out[11:0], sw_p1};
          count_n = Digit_Count + 3'd1;
        end
      end
      HOLD: begin
        if (Ack || Press_Pulse[BTN_CANCEL]) begin
          data_n  = '0;
          count_n = '0;
          state_n = EMPTY;
        end
      end
      default: begin
        data_n  = '0;
        count_n = '0;
        state_n = EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sw_p0       <= '0;
      sw_p1       <= '0;
      state       <= EMPTY;
      Data_Out    <= '0;
      Digit_Count <= '0;
    end else begin
      // p0/p1: switch synchronizer; switches are not debounced
      sw_p0       <= Slide_Switch;
      sw_p1       <= sw_p0;
      state       <= state_n;
      Data_Out    <= data_n;
      Digit_Count <= count_n;
    end
  end

endmodule

// File: tb/tb_user_input_capture.sv
// Directed bench for user_input_capture with a short debounce window.
module tb_user_input_capture;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  Slide_Switch;
  logic [3:0]  Button;
  logic        Ack;
  logic [15:0] Data_Out;
  logic [2:0]  Digit_Count;
  logic        Valid;
  logic [3:0]  Press_Pulse;
  logic        Full;

  int total = 0;
  int bad   = 0;

  user_input_capture #(
    .DEBOUNCE_CYCLES(4),
    .N_DIGITS       (4)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .Slide_Switch(Slide_Switch),
    .Button      (Button),
    .Ack         (Ack),
    .Data_Out    (Data_Out),
    .Digit_Count (Digit_Count),
    .Valid       (Valid),
    .Press_Pulse (Press_Pulse),
    .Full        (Full)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] d, input logic [2:0] c,
                          input logic v, input logic f);
    chk({tag, "_data"},  Data_Out, d);
    chk({tag, "_count"}, 16'(Digit_Count), 16'(c));
    chk({tag, "_valid"}, 16'(Valid), 16'(v));
    chk({tag, "_full"},  16'(Full), 16'(f));
  endtask

  // Raise buttons, expect exactly one pulse 7 edges later, let the FSM
  // update, then release and confirm the release makes no pulse.
  task automatic press(input logic [3:0] mask, input logic [3:0] sw);
    Slide_Switch = sw;
    Button       = mask;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("pulse_early", 16'(Press_Pulse), 16'h0);
    end
    step();
    chk("pulse", 16'(Press_Pulse), 16'(mask));
    step();
    chk("pulse_once", 16'(Press_Pulse), 16'h0);
    Button = 4'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("release", 16'(Press_Pulse), 16'h0);
    end
  endtask

  initial begin
    nRST         = 1'b0;
    Slide_Switch = 4'h0;
    Button       = 4'h0;
    Ack          = 1'b0;
    step();
    step();
    chk_word("reset", 16'h0, 3'd0, 1'b0, 1'b0);
    chk("reset_pulse", 16'(Press_Pulse), 16'h0);
    nRST = 1'b1;
    step();

    // Entry of four digits, an ignored fifth, commit and ack
    press(4'b0001, 4'h1);
    chk_word("e1", 16'h0001, 3'd1, 1'b0, 1'b0);
    press(4'b0001, 4'h2);
    chk_word("e2", 16'h0012, 3'd2, 1'b0, 1'b0);
    press(4'b0001, 4'h3);
    chk_word("e3", 16'h0123, 3'd3, 1'b0, 1'b0);
    press(4'b0001, 4'h4);
    chk_word("e4", 16'h1234, 3'd4, 1'b0, 1'b1);
    press(4'b0001, 4'h5);
    chk_word("e5_ignored", 16'h1234, 3'd4, 1'b0, 1'b1);
    press(4'b0100, 4'h0);
    chk_word("commit", 16'h1234, 3'd4, 1'b1, 1'b1);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk_word("ack", 16'h0, 3'd0, 1'b0, 1'b0);

    // Partial entry, clear, commit
    press(4'b0001, 4'hA);
    press(4'b0001, 4'h5);
    chk_word("pa_a5", 16'h00A5, 3'd2, 1'b0, 1'b0);
    press(4'b0010, 4'h0);
    chk_word("pa_clear", 16'h000A, 3'd1, 1'b0, 1'b0);
    press(4'b0100, 4'h0);
    chk_word("pa_commit", 16'h000A, 3'd1, 1'b1, 1'b0);

    // Presses during HOLD are ignored, cancel releases it
    press(4'b0001, 4'h7);
    chk_word("hold_enter", 16'h000A, 3'd1, 1'b1, 1'b0);
    press(4'b0010, 4'h0);
    chk_word("hold_clear", 16'h000A, 3'd1, 1'b1, 1'b0);
    press(4'b1000, 4'h0);
    chk_word("hold_cancel", 16'h0, 3'd0, 1'b0, 1'b0);

    // Glitch of 3 cycles is filtered out
    Slide_Switch = 4'h9;
    Button       = 4'b0001;
    for (int i = 0; i < 3; i++) step();
    Button = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("glitch", 16'(Press_Pulse), 16'h0);
    end
    chk_word("glitch_state", 16'h0, 3'd0, 1'b0, 1'b0);

    // Simultaneous enter+cancel, then enter+commit
    press(4'b0001, 4'h1);
    chk_word("sim_pre", 16'h0001, 3'd1, 1'b0, 1'b0);
    press(4'b1001, 4'h6);
    chk_word("sim_cancel", 16'h0, 3'd0, 1'b0, 1'b0);
    press(4'b0001, 4'h7);
    press(4'b0101, 4'h8);
    chk_word("sim_commit", 16'h0007, 3'd1, 1'b1, 1'b0);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk_word("sim_ack", 16'h0, 3'd0, 1'b0, 1'b0);

    // Reset mid-entry with enter held across reset
    press(4'b0001, 4'h1);
    press(4'b0001, 4'h2);
    chk_word("pre_rst", 16'h0012, 3'd2, 1'b0, 1'b0);
    Slide_Switch = 4'h3;
    Button       = 4'b0001;
    nRST         = 1'b0;
    step();
    nRST = 1'b1;
    chk_word("mid_rst", 16'h0, 3'd0, 1'b0, 1'b0);
    chk("mid_rst_pulse", 16'(Press_Pulse), 16'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("held_early", 16'(Press_Pulse), 16'h0);
    end
    step();
    chk("held_pulse", 16'(Press_Pulse), 16'h1);
    step();
    chk("held_once", 16'(Press_Pulse), 16'h0);
    chk_word("held_entry", 16'h0003, 3'd1, 1'b0, 1'b0);
    Button = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("held_release", 16'(Press_Pulse), 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
